word_gather: RTL and testbench
==============================

// Module: word_gather
// PURPOSE
//   Upstream packer for the word-sequencing FSM. Collects a valid/ready stream of
//   WIDTH-bit words into an NWORDS-entry frame and presents it as a parallel array.
//   The consumer reads the frame highest index first, so the first accepted word
//   lands in data[NWORDS-1]. Handshakes on both sides. Single clock domain.
// PARAMETERS
//   NWORDS   4   words per frame, >=2
//   WIDTH    32  bits per word
//   TIMEOUT  16  idle cycles before a partial frame is flushed (GATHER_TIMEOUT_EN only)
// PORTS
//   clk        in   1             clock; all state changes on rising edge
//   reset      in   1             asynchronous, active-low reset
//   in_valid   in   1             upstream word valid
//   in_ready   out  1             block can accept a word
//   in_data    in   WIDTH         upstream word
//   in_last    in   1             word closes the frame early
//   out_valid  out  1             frame complete and held
//   out_ready  in   1             consumer takes frame
//   data       out  NWORDS*WIDTH  frame, packed [NWORDS-1:0][WIDTH-1:0]
//   out_count  out  $clog2(NWORDS+1)  number of valid words in frame (1..NWORDS)
// BEHAVIOUR
//   - Reset (reset=0, async): state=IDLE, data=0, out_count=0, out_valid=0,
//     idle counter=0. in_ready forced 0 while reset=0.
//   - States: IDLE (0 words), FILL (1..NWORDS-1 words), FULL (frame held).
//   - in_ready = 1 in IDLE/FILL, 0 in FULL (combinational from state; no bypass).
//   - Accept = in_valid & in_ready at a rising edge. Word k of a frame (k=0 first)
//     is written to data[NWORDS-1-k]; out_count increments by 1.
//   - IDLE/FILL -> FULL on accept when out_count becomes NWORDS or in_last=1.
//     IDLE -> FILL on accept otherwise. FILL stays FILL otherwise.
//   - out_valid = 1 exactly in FULL; asserts the cycle after the completing accept
//     (1-cycle latency). data/out_count are stable while out_valid=1.
//   - FULL -> IDLE on out_ready=1; same edge clears data to 0 and out_count to 0.
//     No word is accepted on that edge (in_ready=0 in FULL).
//   - Unfilled slots of a short frame read 0.
//   - in_last while in FILL with the final slot is identical to a full frame.
//   - out_ready while not FULL is ignored. in_data ignored when not accepted.
//   - Reset mid-frame discards the partial or held frame, no output produced.
//   - Throughput: one full frame per NWORDS+1 cycles with out_ready tied 1.
// CONFIGURATION
//   GATHER_TIMEOUT_EN defined:
//     - idle counter clears on every accept and on entry to FILL; increments each
//       FILL cycle with no accept. Reaching TIMEOUT forces FILL -> FULL with the
//       current out_count (partial flush). Counter inactive in IDLE/FULL.
//     - an accept on the same edge as the timeout wins; the counter clears.
//   GATHER_TIMEOUT_EN undefined: no counter; FILL waits indefinitely; TIMEOUT unused.
// TESTING
//   1. in_valid=1, words A,B,C,D on 4 edges, out_ready=0 -> out_valid=1 next cycle,
//      data[3]=A, data[2]=B, data[1]=C, data[0]=D, out_count=4, in_ready=0.
//   2. Hold out_ready=0 for 5 cycles after test 1 with in_valid=1 -> data unchanged,
//      no accepts; then out_ready=1 for 1 cycle -> IDLE, data=0, in_ready=1.
//   3. Words 0x11, 0x22 with in_last=1 on 0x22 -> out_count=2, data[3]=0x11,
//      data[2]=0x22, data[1:0]=0.
//   4. Accept 2 words, pulse reset=0 mid-frame -> out_valid=0, out_count=0,
//      data=0; next 4 words form a clean frame with the first in data[3].
//   5. (GATHER_TIMEOUT_EN, TIMEOUT=16) accept 1 word, then in_valid=0 -> out_valid=1
//      after 16 idle cycles, out_count=1; an accept at idle cycle 15 restarts count.
//   6. out_ready=1 and in_valid=1 throughout, 3 frames -> one frame every 5 cycles,
//      words stored in order, none lost or duplicated.

Source files
------------

// File: rtl/word_gather_if.sv
// Bundle carrying both handshakes of word_gather: word stream in, frame out.
// A transfer happens on a rising edge where valid and ready are both 1; a source
// keeps valid and its payload stable until that edge, and ready never waits on valid.
interface word_gather_if #(
  parameter int NWORDS = 4,
  parameter int WIDTH  = 32
);
  logic                           in_valid;
  logic                           in_ready;
  logic [WIDTH-1:0]               in_data;
  logic                           in_last;
  logic                           out_valid;
  logic                           out_ready;
  logic [NWORDS-1:0][WIDTH-1:0]   data;
  logic [$clog2(NWORDS+1)-1:0]    out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, data, out_count
  );
endinterface

// File: rtl/word_gather.sv
// Packs a valid/ready word stream into an NWORDS frame, first word in the top slot.
// Optional partial-frame flush after TIMEOUT idle cycles: define GATHER_TIMEOUT_EN.
module word_gather #(
  parameter int NWORDS  = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  word_gather_if.slave  bus,
  output logic [1:0]    dbg_state_o
);
  localparam int CW = $clog2(NWORDS + 1);
  localparam int IW = $clog2(NWORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                count_q, count_d;
  logic [NWORDS-1:0][WIDTH-1:0] data_q, data_d;
  logic                         in_ready;
  logic                         accept;
  logic [IW-1:0]                wr_idx;
  logic [CW-1:0]                count_inc;

`ifdef GATHER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q, idle_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Ready is held low during reset so nothing is taken while state is clearing.
  assign in_ready  = reset && (state_q != S_FULL);
  assign accept    = bus.in_valid && in_ready;
  assign wr_idx    = IW'(NWORDS - 1) - count_q[IW-1:0];
  assign count_inc = count_q + CW'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
`ifdef GATHER_TIMEOUT_EN
    idle_d  = idle_q;
`endif
    case (state_q)
      S_IDLE, S_FILL: begin
        if (accept) begin
          data_d[wr_idx] = bus.in_data;
          count_d        = count_inc;
`ifdef GATHER_TIMEOUT_EN
          idle_d         = '0;
`endif
          if ((count_inc == CW'(NWORDS)) || bus.in_last) state_d = S_FULL;
          else                                          state_d = S_FILL;
        end
`ifdef GATHER_TIMEOUT_EN
        else if (state_q == S_FILL) begin
          // This edge is the TIMEOUT-th idle cycle: flush what we have.
          if (idle_q == TW'(TIMEOUT - 1)) begin
            state_d = S_FULL;
            idle_d  = '0;
          end else begin
            idle_d  = idle_q + TW'(1);
          end
        end
`endif
      end
      S_FULL: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
          count_d = '0;
          data_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      data_q  <= '0;
`ifdef GATHER_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
`ifdef GATHER_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == S_FULL);
  assign bus.data      = data_q;
  assign bus.out_count = count_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_word_gather.sv
// Randomized and directed bench for word_gather against a word-queue reference model.
// Build with +define+GATHER_TIMEOUT_EN to exercise the partial-frame flush.
module tb_word_gather;
  localparam int NWORDS  = 4;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;
  localparam int FW      = NWORDS * WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  word_gather_if #(.NWORDS(NWORDS), .WIDTH(WIDTH)) bus ();
  logic [1:0] dbg_state;

  word_gather #(.NWORDS(NWORDS), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is just the ordered list of accepted words plus a "held" flag.
  logic [WIDTH-1:0] m_words[$];
  bit               m_held;
  int               m_idle;
  logic [FW-1:0]    exp_q[$];

  function automatic logic [FW-1:0] m_frame();
    logic [NWORDS-1:0][WIDTH-1:0] f;
    f = '0;
    for (int k = 0; k < m_words.size(); k++) f[NWORDS-1-k] = m_words[k];
    return f;
  endfunction

  function automatic void model_reset();
    m_words.delete();
    m_held = 0;
    m_idle = 0;
    exp_q.delete();
  endfunction

  function automatic void model_step(input bit v, input logic [WIDTH-1:0] d, input bit l, input bit r);
    if (m_held) begin
      if (r) begin
        m_words.delete();
        m_held = 0;
        m_idle = 0;
      end
    end else if (v) begin
      m_words.push_back(d);
      m_idle = 0;
      if (m_words.size() == NWORDS || l) begin
        m_held = 1;
        exp_q.push_back(m_frame());
      end
    end
`ifdef GATHER_TIMEOUT_EN
    else if (m_words.size() != 0) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_held = 1;
        m_idle = 0;
        exp_q.push_back(m_frame());
      end
    end
`endif
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".in_ready"},  FW'(bus.in_ready),  FW'(reset && !m_held));
    check({tag, ".out_valid"}, FW'(bus.out_valid), FW'(m_held));
    check({tag, ".out_count"}, FW'(bus.out_count), FW'(m_words.size()));
    check({tag, ".data"},      bus.data,           m_frame());
    check({tag, ".dbg_legal"}, FW'(dbg_state == 2'd3), FW'(0));
  endtask

  // ---------------- driver ----------------
  bit               collect;
  logic [WIDTH-1:0] got_words[$];
  int               hs_cyc[$];

  task automatic cycle(input string tag, input bit v, input logic [WIDTH-1:0] d,
                       input bit l, input bit r, output bit acc);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = r;
    if (m_held && r) begin
      if (exp_q.size() == 0) check("sb_empty", FW'(1), FW'(0));
      else                   check("sb_frame", bus.data, exp_q.pop_front());
      if (collect) begin
        hs_cyc.push_back(cyc);
        for (int k = 0; k < m_words.size(); k++) got_words.push_back(bus.data[NWORDS-1-k]);
      end
    end
    acc = !m_held && v;
    @(posedge clk);
    cyc++;
    model_step(v, d, l, r);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic drain(input string tag);
    bit acc;
    int guard = 0;
    while (!m_held && guard < 2 * NWORDS) begin
      cycle(tag, 1'b1, $urandom, 1'b1, 1'b0, acc);
      guard++;
    end
    cycle(tag, 1'b0, '0, 1'b0, 1'b1, acc);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [WIDTH-1:0] WA = 32'hA0A0_0001;
  localparam logic [WIDTH-1:0] WB = 32'hB0B0_0002;
  localparam logic [WIDTH-1:0] WC = 32'hC0C0_0003;
  localparam logic [WIDTH-1:0] WD = 32'hD0D0_0004;

  initial begin
    bit acc;
    logic [WIDTH-1:0] w[$];
    logic [WIDTH-1:0] t6[$];
    int idx;
    int guard;

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    collect       = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    reset = 1'b1;
    #1 check_outputs("post_reset");

    // Four words fill a frame, first word in the top slot.
    cycle("t1", 1'b1, WA, 1'b0, 1'b0, acc);
    cycle("t1", 1'b1, WB, 1'b0, 1'b0, acc);
    cycle("t1", 1'b1, WC, 1'b0, 1'b0, acc);
    cycle("t1", 1'b1, WD, 1'b0, 1'b0, acc);
    check("t1_data",      bus.data, {WA, WB, WC, WD});
    check("t1_count",     FW'(bus.out_count), FW'(4));
    check("t1_out_valid", FW'(bus.out_valid), FW'(1));
    check("t1_in_ready",  FW'(bus.in_ready),  FW'(0));

    // Held frame ignores further words until the consumer takes it.
    repeat (5) cycle("t2", 1'b1, $urandom, 1'b0, 1'b0, acc);
    check("t2_hold", bus.data, {WA, WB, WC, WD});
    cycle("t2", 1'b0, '0, 1'b0, 1'b1, acc);
    check("t2_clear",    bus.data, '0);
    check("t2_in_ready", FW'(bus.in_ready), FW'(1));

    // Short frame closed by in_last.
    cycle("t3", 1'b1, 32'h11, 1'b0, 1'b0, acc);
    cycle("t3", 1'b1, 32'h22, 1'b1, 1'b0, acc);
    check("t3_count", FW'(bus.out_count), FW'(2));
    check("t3_data",  bus.data, {32'h11, 32'h22, 64'h0});
    cycle("t3", 1'b0, '0, 1'b0, 1'b1, acc);

    // Reset in the middle of a frame discards it.
    cycle("t4", 1'b1, 32'h55, 1'b0, 1'b0, acc);
    cycle("t4", 1'b1, 32'h66, 1'b0, 1'b0, acc);
    reset = 1'b0;
    model_reset();
    #1 check_outputs("t4_rst");
    check("t4_rst_data", bus.data, '0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    w = '{32'h1001, 32'h1002, 32'h1003, 32'h1004};
    foreach (w[i]) cycle("t4", 1'b1, w[i], 1'b0, 1'b0, acc);
    check("t4_frame", bus.data, {w[0], w[1], w[2], w[3]});
    cycle("t4", 1'b0, '0, 1'b0, 1'b1, acc);

    // Idle gaps inside a frame; an accept at idle cycle 15 restarts the count.
    cycle("t5", 1'b1, 32'h77, 1'b0, 1'b0, acc);
    repeat (TIMEOUT - 1) cycle("t5", 1'b0, '0, 1'b0, 1'b0, acc);
    check("t5_no_flush_yet", FW'(bus.out_valid), FW'(0));
    cycle("t5", 1'b1, 32'h88, 1'b0, 1'b0, acc);
    repeat (TIMEOUT - 1) cycle("t5", 1'b0, '0, 1'b0, 1'b0, acc);
    check("t5_restart", FW'(bus.out_valid), FW'(0));
    cycle("t5", 1'b0, '0, 1'b0, 1'b0, acc);
`ifdef GATHER_TIMEOUT_EN
    check("t5_flush",       FW'(bus.out_valid), FW'(1));
    check("t5_flush_count", FW'(bus.out_count), FW'(2));
`else
    check("t5_wait",        FW'(bus.out_valid), FW'(0));
    check("t5_wait_count",  FW'(bus.out_count), FW'(2));
`endif
    drain("t5");

    // Streaming with out_ready tied high: a frame every NWORDS+1 cycles.
    for (int i = 0; i < 3 * NWORDS; i++) t6.push_back(32'h6000 + i);
    collect = 1;
    got_words.delete();
    hs_cyc.delete();
    idx   = 0;
    guard = 0;
    while (idx < t6.size() && guard < 100) begin
      cycle("t6", 1'b1, t6[idx], 1'b0, 1'b1, acc);
      if (acc) idx++;
      guard++;
    end
    check("t6_budget", FW'(guard < 100), FW'(1));
    cycle("t6", 1'b0, '0, 1'b0, 1'b1, acc);
    collect = 0;
    check("t6_nwords", FW'(got_words.size()), FW'(t6.size()));
    for (int i = 0; i < got_words.size() && i < t6.size(); i++)
      check("t6_word", FW'(got_words[i]), FW'(t6[i]));
    check("t6_nframes", FW'(hs_cyc.size()), FW'(3));
    for (int i = 1; i < hs_cyc.size(); i++)
      check("t6_period", FW'(hs_cyc[i] - hs_cyc[i-1]), FW'(NWORDS + 1));

    // Random traffic with idle bursts long enough to reach the timeout.
    for (int i = 0; i < 600; i++) begin
      bit v;
      v = ((i % 150) < 20) ? 1'b0 : ($urandom_range(0, 3) != 0);
      cycle("rand", v, $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, acc);
    end
    drain("rand_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
